hangman_plotter: RTL and testbench

Pixel-job sequencer between the game datapath and `vga_adapter`. Watches the revealed-letter mask and the wrong-guess count. Each time a letter is newly revealed or a wrong guess is added, it sweeps the matching rectangle into the 160x120 framebuffer, one pixel per cycle. It also performs a full-screen clear on request, then redraws whatever the current game state still shows.

---
 rtl/hangman_gfx_pkg.sv | 57 +++++
 rtl/rect_sweeper.sv | 75 +++++++
 rtl/hangman_plotter.sv | 166 ++++++++++++++++
 tb/tb_hangman_plotter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_gfx_pkg.sv
// Shared encodings, colours and hangman part geometry for the hangman plotter.
package hangman_gfx_pkg;

  localparam int unsigned XW        = 8;
  localparam int unsigned YW        = 7;
  localparam int unsigned COLW      = 3;
  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned PARTW     = 3;
  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;

  localparam logic [COLW-1:0] COL_LETTER = 3'b010;
  localparam logic [COLW-1:0] COL_PART   = 3'b111;
  localparam logic [COLW-1:0] COL_BG     = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLOT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    JOB_CLR    = 2'd0,
    JOB_LETTER = 2'd1,
    JOB_PART   = 2'd2
  } job_e;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
  } rect_t;

  localparam rect_t PART_HEAD  = '{x0: 8'd70, y0: 7'd20, w: 8'd8,  h: 7'd8};
  localparam rect_t PART_BODY  = '{x0: 8'd73, y0: 7'd28, w: 8'd2,  h: 7'd20};
  localparam rect_t PART_LARM  = '{x0: 8'd63, y0: 7'd32, w: 8'd10, h: 7'd2};
  localparam rect_t PART_RARM  = '{x0: 8'd75, y0: 7'd32, w: 8'd10, h: 7'd2};
  localparam rect_t PART_LLEG  = '{x0: 8'd66, y0: 7'd48, w: 8'd7,  h: 7'd2};
  localparam rect_t PART_RLEG  = '{x0: 8'd75, y0: 7'd48, w: 8'd7,  h: 7'd2};

  // k is the 1-based part number; values outside 1..6 never reach here
  function automatic rect_t part_rect(input logic [PARTW-1:0] k);
    rect_t r;
    case (k)
      3'd1:    r = PART_HEAD;
      3'd2:    r = PART_BODY;
      3'd3:    r = PART_LARM;
      3'd4:    r = PART_RARM;
      3'd5:    r = PART_LLEG;
      3'd6:    r = PART_RLEG;
      default: r = PART_HEAD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rect_sweeper.sv
// Raster-scans one rectangle, one pixel per cycle; x is the inner loop.
module rect_sweeper
  import hangman_gfx_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          last
);

  logic [XW-1:0] x_q, x_d, x0_q, x0_d, xend_q, xend_d;
  logic [YW-1:0] y_q, y_d, yend_q, yend_d;
  logic          active_q, active_d, last_q, last_d;

  // last is registered alongside x/y so it flags the pixel currently presented
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    xend_d   = xend_q;
    yend_d   = yend_q;
    active_d = active_q;
    if (start) begin
      x0_d     = x0;
      xend_d   = x0 + w - 8'd1;
      yend_d   = y0 + h - 7'd1;
      x_d      = x0;
      y_d      = y0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last_q) begin
        active_d = 1'b0;
      end else if (x_q == xend_q) begin
        x_d = x0_q;
        y_d = y_q + 7'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
    last_d = active_d && (x_d == xend_d) && (y_d == yend_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      xend_q   <= '0;
      yend_q   <= '0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      xend_q   <= xend_d;
      yend_q   <= yend_d;
      active_q <= active_d;
      last_q   <= last_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign active = active_q;
  assign last   = last_q;

endmodule

// File: rtl/hangman_plotter.sv
// Turns newly revealed letters, new hangman parts and clear requests into
// rectangle fill jobs for the framebuffer, one pixel per cycle.
module hangman_plotter
  import hangman_gfx_pkg::*;
#(
  parameter int unsigned LETTER_X0  = 40,
  parameter int unsigned LETTER_Y   = 100,
  parameter int unsigned SLOT_PITCH = 8,
  parameter int unsigned LETTER_W   = 4,
  parameter int unsigned LETTER_H   = 6,
  parameter int unsigned MAX_PARTS  = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] letter_mask,
  input  logic [5:0] wrong_count,
  input  logic       clear_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_e                 state_q, state_d;
  job_e                   job_q, job_d;
  logic [2:0]             slot_q, slot_d;
  logic [NUM_SLOTS-1:0]   drawn_q, drawn_d;
  logic [PARTW-1:0]       parts_q, parts_d;
  logic                   clr_pend_q, clr_pend_d;
  logic [COLW-1:0]        colour_q, colour_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [NUM_SLOTS-1:0]   pend_letters_c;
  logic [2:0]             first_slot_c;
  logic [PARTW-1:0]       sat_parts_c;
  logic                   part_pend_c;
  logic                   sweep_start_c;
  rect_t                  rect_c;
  logic                   sw_active, sw_last;

  // Slot 0 lives in mask bit 4, so the lowest slot is the highest set bit
  always_comb begin
    pend_letters_c = letter_mask & ~drawn_q;
    first_slot_c   = '0;
    for (int b = 0; b < NUM_SLOTS; b++) begin
      if (pend_letters_c[b]) first_slot_c = 3'(NUM_SLOTS - 1 - b);
    end
    sat_parts_c = (wrong_count > 6'(MAX_PARTS)) ? PARTW'(MAX_PARTS)
                                                : wrong_count[PARTW-1:0];
    part_pend_c = (sat_parts_c > parts_q);
  end

  always_comb begin
    state_d       = state_q;
    job_d         = job_q;
    slot_d        = slot_q;
    drawn_d       = drawn_q;
    parts_d       = parts_q;
    clr_pend_d    = clr_pend_q;
    colour_d      = colour_q;
    done_d        = 1'b0;
    sweep_start_c = 1'b0;
    rect_c        = '0;

    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          job_d   = JOB_CLR;
          state_d = ST_LOAD;
        end else if (|pend_letters_c) begin
          job_d   = JOB_LETTER;
          slot_d  = first_slot_c;
          state_d = ST_LOAD;
        end else if (part_pend_c) begin
          job_d   = JOB_PART;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sweep_start_c = 1'b1;
        state_d       = ST_PLOT;
        case (job_q)
          JOB_CLR: begin
            rect_c.w   = XW'(SCREEN_W);
            rect_c.h   = YW'(SCREEN_H);
            colour_d   = COL_BG;
            drawn_d    = '0;
            parts_d    = '0;
            clr_pend_d = 1'b0;
          end
          JOB_LETTER: begin
            rect_c.x0 = XW'(LETTER_X0 + SLOT_PITCH * 32'(slot_q));
            rect_c.y0 = YW'(LETTER_Y);
            rect_c.w  = XW'(LETTER_W);
            rect_c.h  = YW'(LETTER_H);
            colour_d  = COL_LETTER;
            drawn_d   = drawn_q | (5'b10000 >> slot_q);
          end
          default: begin
            parts_d  = parts_q + PARTW'(1);
            rect_c   = part_rect(parts_q + PARTW'(1));
            colour_d = COL_PART;
          end
        endcase
      end
      ST_PLOT: begin
        if (sw_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request arriving during any state is remembered, never dropped
    if (clear_req) clr_pend_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      job_q      <= JOB_CLR;
      slot_q     <= '0;
      drawn_q    <= '0;
      parts_q    <= '0;
      clr_pend_q <= 1'b0;
      colour_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      job_q      <= job_d;
      slot_q     <= slot_d;
      drawn_q    <= drawn_d;
      parts_q    <= parts_d;
      clr_pend_q <= clr_pend_d;
      colour_q   <= colour_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  rect_sweeper u_sweeper (
    .clk    (clk),
    .resetn (resetn),
    .start  (sweep_start_c),
    .x0     (rect_c.x0),
    .y0     (rect_c.y0),
    .w      (rect_c.w),
    .h      (rect_c.h),
    .x      (x),
    .y      (y),
    .active (sw_active),
    .last   (sw_last)
  );

  assign plot   = sw_active;
  assign colour = colour_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_hangman_plotter.sv
// Directed scoreboard bench for hangman_plotter: expected pixels are queued at
// stimulus time and popped whenever plot is sampled high.
module tb_hangman_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] letter_mask;
  logic [5:0] wrong_count;
  logic       clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int checks = 0;
  int errors = 0;
  int first_plot_cyc;
  int last_gap;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

  hangman_plotter dut (
    .clk         (clk),
    .resetn      (resetn),
    .letter_mask (letter_mask),
    .wrong_count (wrong_count),
    .clear_req   (clear_req),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input logic [2:0] col);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        sb.push_back({8'(x0 + i), 7'(y0 + j), col});
  endtask

  task automatic push_letter(input int s);
    push_rect(40 + 8 * s, 100, 4, 6, 3'b010);
  endtask

  task automatic push_part(input int k);
    case (k)
      1: push_rect(70, 20, 8, 8, 3'b111);
      2: push_rect(73, 28, 2, 20, 3'b111);
      3: push_rect(63, 32, 10, 2, 3'b111);
      4: push_rect(75, 32, 10, 2, 3'b111);
      5: push_rect(66, 48, 7, 2, 3'b111);
      6: push_rect(75, 48, 7, 2, 3'b111);
      default: ;
    endcase
  endtask

  // Samples on falling edges until the queue drains and n_done pulses are seen
  task automatic run_jobs(input string tag, input int n_done, input int budget,
                          input int clr_at);
    int cyc = 0;
    int dones = 0;
    int gap = 0;
    bit started = 1'b0;
    logic [17:0] e;
    first_plot_cyc = -1;
    last_gap = -1;
    while ((sb.size() != 0 || dones < n_done) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      clear_req = (cyc == clr_at);
      if (plot) begin
        if (first_plot_cyc < 0) first_plot_cyc = cyc;
        if (started && gap > 0) last_gap = gap;
        gap = 0;
        started = 1'b1;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL %s extra pixel obs x=%0d y=%0d col=%0d exp none", tag, x, y, colour);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert ({busy, x, y, colour} === {1'b1, e}) else begin
            errors++;
            $error("FAIL %s pixel obs busy=%b x=%0d y=%0d col=%0d exp busy=1 x=%0d y=%0d col=%0d",
                   tag, busy, x, y, colour, e[17:10], e[9:3], e[2:0]);
          end
        end
      end else if (started) begin
        gap++;
      end
      if (done) dones++;
    end
    clear_req = 1'b0;
    checks++;
    assert (dones == n_done && sb.size() == 0) else begin
      errors++;
      $error("FAIL %s_end obs dones=%0d left=%0d exp dones=%0d left=0", tag, dones, sb.size(), n_done);
      sb.delete();
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      assert ({plot, busy, done} === 3'b000) else begin
        errors++;
        $error("FAIL %s obs plot/busy/done=%b exp 000", tag, {plot, busy, done});
      end
    end
  endtask

  task automatic check_latency(input string tag);
    checks++;
    assert (first_plot_cyc == 2) else begin
      errors++;
      $error("FAIL %s_latency obs %0d exp 2", tag, first_plot_cyc);
    end
  endtask

  task automatic check_gap(input string tag);
    checks++;
    assert (last_gap == 2) else begin
      errors++;
      $error("FAIL %s_gap obs %0d exp 2", tag, last_gap);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    resetn      = 1'b0;
    letter_mask = '0;
    wrong_count = '0;
    clear_req   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    assert ({x, y, colour, plot, busy, done} === '0) else begin
      errors++;
      $error("FAIL reset obs x=%0d y=%0d col=%0d p/b/d=%b exp all 0", x, y, colour, {plot, busy, done});
    end
    resetn = 1'b1;
    idle_check("post_reset", 3);

    // Single letter in slot 0
    letter_mask = 5'b10000;
    push_letter(0);
    run_jobs("slot0", 1, 100, -1);
    check_latency("slot0");
    idle_check("after_slot0", 4);

    // Two letters revealed together: lowest slot first, 2-cycle gap
    letter_mask = 5'b11100;
    push_letter(1);
    push_letter(2);
    run_jobs("slot12", 2, 200, -1);
    check_latency("slot12");
    check_gap("slot12");

    // Head, with a clear request mid-sweep, then full redraw of current state
    wrong_count = 6'd1;
    push_part(1);
    push_rect(0, 0, 160, 120, 3'b000);
    push_letter(0);
    push_letter(1);
    push_letter(2);
    push_part(1);
    run_jobs("head_clear", 6, 20000, 20);

    // Letter and part pending together: letter wins
    wrong_count = 6'd2;
    letter_mask = 5'b11110;
    push_letter(3);
    push_part(2);
    run_jobs("prio", 2, 300, -1);
    check_latency("prio");
    check_gap("prio");

    // Count jumps past the limit: parts 3..6 only, then saturation
    wrong_count = 6'd9;
    for (int k = 3; k <= 6; k++) push_part(k);
    run_jobs("parts", 4, 400, -1);
    idle_check("saturate", 10);

    // Falling inputs never un-draw
    wrong_count = 6'd0;
    letter_mask = 5'b00000;
    idle_check("no_undraw", 5);

    // Reset in the middle of a clear sweep
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_cyc = 0;
    while (!plot && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    assert ({plot, colour} === 4'b1000) else begin
      errors++;
      $error("FAIL clear_start obs plot=%b col=%0d exp plot=1 col=0", plot, colour);
    end
    repeat (50) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    assert ({plot, busy, done, x, y, colour} === '0) else begin
      errors++;
      $error("FAIL reset_mid obs p/b/d=%b x=%0d y=%0d col=%0d exp all 0", {plot, busy, done}, x, y, colour);
    end
    @(negedge clk);
    resetn = 1'b1;
    idle_check("post_reset2", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
